// File: rtl/gray_ptr_sync.sv
// Multi-stage gray-code pointer synchronizer for async FIFO pointer crossings.
// Adds a registered binary decode, a per-step pulse and illegal-transition detection.
module gray_ptr_sync #(
   parameter int unsigned ASIZE  = 3,
   parameter int unsigned STAGES = 2
) (
   input  logic             dest_clk,
   input  logic             in_reset,
   input  logic [ASIZE:0]   async_signal,
   output logic [ASIZE:0]   sync_signal,
   output logic [ASIZE:0]   sync_bin,
   output logic             sync_valid,
   output logic             step,
   output logic             gray_err,
   output logic [7:0]       err_cnt
);

   localparam int unsigned PW   = ASIZE + 1;
   localparam int unsigned CW   = $clog2(STAGES + 2);
   localparam int unsigned FULL = STAGES + 1;

   if ((STAGES < 2) || (STAGES > 8)) begin : g_bad_stages
      $error("gray_ptr_sync: STAGES must be in 2..8");
   end

   logic [PW-1:0] chain_q [STAGES];
   logic [PW-1:0] chain_d [STAGES];
   logic [PW-1:0] cmp_q, cmp_d;
   logic [PW-1:0] sync_bin_q, sync_bin_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sync_valid_q, sync_valid_d;
   logic          step_q, step_d;
   logic          gray_err_q, gray_err_d;
   logic [7:0]    err_cnt_q, err_cnt_d;
   logic [PW-1:0] diff;
   logic          multi_bit;

   // Synchronizer chain: stage 0 samples the asynchronous pointer.
   always_comb begin
      chain_d[0] = async_signal;
      for (int k = 1; k < STAGES; k++) begin
         chain_d[k] = chain_q[k-1];
      end
   end

   assign sync_signal = chain_q[STAGES-1];

   // Decode, fill tracking and transition checks.
   always_comb begin
      for (int i = 0; i < PW; i++) begin
         sync_bin_d[i] = ^(sync_signal >> i);
      end
      cmp_d        = sync_signal;
      diff         = sync_signal ^ cmp_q;
      multi_bit    = (diff & (diff - PW'(1))) != '0;
      cnt_d        = (cnt_q == CW'(FULL)) ? cnt_q : cnt_q + CW'(1);
      sync_valid_d = (cnt_d == CW'(FULL));
      step_d       = 1'b0;
      gray_err_d   = gray_err_q;
      err_cnt_d    = err_cnt_q;
      if (sync_valid_q) begin
         step_d = (diff != '0);
         if (multi_bit) begin
            gray_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
               err_cnt_d = err_cnt_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge dest_clk) begin
      if (in_reset) begin
         for (int k = 0; k < STAGES; k++) begin
            chain_q[k] <= '0;
         end
         cmp_q        <= '0;
         sync_bin_q   <= '0;
         cnt_q        <= '0;
         sync_valid_q <= 1'b0;
         step_q       <= 1'b0;
         gray_err_q   <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            chain_q[k] <= chain_d[k];
         end
         cmp_q        <= cmp_d;
         sync_bin_q   <= sync_bin_d;
         cnt_q        <= cnt_d;
         sync_valid_q <= sync_valid_d;
         step_q       <= step_d;
         gray_err_q   <= gray_err_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign sync_bin   = sync_bin_q;
   assign sync_valid = sync_valid_q;
   assign step       = step_q;
   assign gray_err   = gray_err_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Self-checking bench for gray_ptr_sync: default (3,2) instance plus a (4,4) depth instance.
module tb_gray_ptr_sync;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0 = 1'b1;
   logic [3:0] async0 = 4'b0110;
   logic [3:0] sync_sig0, sync_bin0;
   logic       sync_valid0, step0, gray_err0;
   logic [7:0] err_cnt0;

   logic       rst1 = 1'b1;
   logic [4:0] async1 = 5'b00000;
   logic [4:0] sync_sig1, sync_bin1;
   logic       sync_valid1, step1, gray_err1;
   logic [7:0] err_cnt1;

   int n_tests = 0;
   int n_fail  = 0;

   gray_ptr_sync #(.ASIZE(3), .STAGES(2)) u_dut0 (
      .dest_clk(clk), .in_reset(rst0), .async_signal(async0),
      .sync_signal(sync_sig0), .sync_bin(sync_bin0), .sync_valid(sync_valid0),
      .step(step0), .gray_err(gray_err0), .err_cnt(err_cnt0)
   );

   gray_ptr_sync #(.ASIZE(4), .STAGES(4)) u_dut1 (
      .dest_clk(clk), .in_reset(rst1), .async_signal(async1),
      .sync_signal(sync_sig1), .sync_bin(sync_bin1), .sync_valid(sync_valid1),
      .step(step1), .gray_err(gray_err1), .err_cnt(err_cnt1)
   );

   // Advance one edge and settle past it; inputs changed after this are captured next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset0(input logic [3:0] val);
      async0 = val;
      rst0   = 1'b1;
      tick();
      tick();
      rst0 = 1'b0;
      repeat (6) tick();
   endtask

   task automatic test_reset();
      async0 = 4'b0110;
      rst0   = 1'b1;
      tick();
      tick();
      n_tests++;
      if ({sync_sig0, sync_bin0, sync_valid0, step0, gray_err0, err_cnt0} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: sig=%b bin=%0d valid=%b step=%b err=%b cnt=%0d, required all 0",
                  sync_sig0, sync_bin0, sync_valid0, step0, gray_err0, err_cnt0);
      end
      rst0 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         n_tests++;
         if (sync_sig0 !== ((k >= 2) ? 4'b0110 : 4'b0000)) begin
            n_fail++;
            $display("FAIL fill_sync_signal edge %0d: got %b", k, sync_sig0);
         end
         n_tests++;
         if (sync_valid0 !== (k >= 3)) begin
            n_fail++;
            $display("FAIL fill_valid edge %0d: got %b required %b", k, sync_valid0, (k >= 3));
         end
         if (k >= 3) begin
            n_tests++;
            if (sync_bin0 !== 4'd4) begin
               n_fail++;
               $display("FAIL fill_bin edge %0d: got %0d required 4", k, sync_bin0);
            end
         end
         n_tests++;
         if (step0 !== 1'b0 || gray_err0 !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_quiet edge %0d: step=%b err=%b required 0 0", k, step0, gray_err0);
         end
      end
   endtask

   task automatic test_count_wrap();
      logic [3:0] exp_q[$];
      logic [3:0] b, g, exp;
      int steps;
      steps = 0;
      do_reset0(4'b0000);
      for (int v = 1; v <= 16; v++) begin
         b      = 4'(v);
         g      = b ^ (b >> 1);
         async0 = g;
         exp_q.push_back(b);
         for (int t = 0; t < 3; t++) begin
            tick();
            if (step0 === 1'b1) begin
               steps++;
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL count_step: unexpected step, bin=%0d", sync_bin0);
               end else begin
                  exp = exp_q.pop_front();
                  if (sync_bin0 !== exp || t != 2) begin
                     n_fail++;
                     $display("FAIL count_bin: got %0d at tick %0d required %0d at tick 2",
                              sync_bin0, t, exp);
                  end
               end
            end
         end
      end
      n_tests++;
      if (steps != 16 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL count_steps: got %0d pulses (%0d pending) required 16", steps, exp_q.size());
      end
      n_tests++;
      if (gray_err0 !== 1'b0 || err_cnt0 !== 8'd0) begin
         n_fail++;
         $display("FAIL count_err: err=%b cnt=%0d required 0 0", gray_err0, err_cnt0);
      end
   endtask

   task automatic test_illegal();
      repeat (2) tick();
      async0 = 4'b0011;
      tick();
      tick();
      n_tests++;
      if (gray_err0 !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_early: err=%b required 0", gray_err0);
      end
      tick();
      n_tests++;
      if (gray_err0 !== 1'b1 || err_cnt0 !== 8'd1 || sync_bin0 !== 4'd2 || step0 !== 1'b1) begin
         n_fail++;
         $display("FAIL illegal_jump: err=%b cnt=%0d bin=%0d step=%b required 1 1 2 1",
                  gray_err0, err_cnt0, sync_bin0, step0);
      end
      async0 = 4'b0010;
      repeat (3) tick();
      n_tests++;
      if (gray_err0 !== 1'b1 || err_cnt0 !== 8'd1 || sync_bin0 !== 4'd3) begin
         n_fail++;
         $display("FAIL illegal_sticky: err=%b cnt=%0d bin=%0d required 1 1 3",
                  gray_err0, err_cnt0, sync_bin0);
      end
   endtask

   task automatic test_saturate();
      int model;
      do_reset0(4'b0000);
      for (int i = 0; i < 300; i++) begin
         async0 = (i % 2 == 0) ? 4'b0011 : 4'b0000;
         repeat (3) tick();
         model = (i + 1 > 255) ? 255 : i + 1;
         n_tests++;
         if (err_cnt0 !== 8'(model)) begin
            n_fail++;
            $display("FAIL saturate_cnt %0d: got %0d required %0d", i, err_cnt0, model);
         end
      end
      repeat (5) tick();
      n_tests++;
      if (err_cnt0 !== 8'd255 || gray_err0 !== 1'b1) begin
         n_fail++;
         $display("FAIL saturate_hold: cnt=%0d err=%b required 255 1", err_cnt0, gray_err0);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] seq [5];
      seq = '{4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b1101};
      do_reset0(4'b0000);
      for (int i = 0; i < 5; i++) begin
         async0 = seq[i];
         repeat (3) tick();
      end
      n_tests++;
      if (sync_bin0 !== 4'd9 || gray_err0 !== 1'b1 || err_cnt0 !== 8'd5) begin
         n_fail++;
         $display("FAIL mid_setup: bin=%0d err=%b cnt=%0d required 9 1 5", sync_bin0, gray_err0, err_cnt0);
      end
      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;
      n_tests++;
      if ({sync_sig0, sync_bin0, sync_valid0, step0, gray_err0, err_cnt0} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: sig=%b bin=%0d valid=%b step=%b err=%b cnt=%0d, required all 0",
                  sync_sig0, sync_bin0, sync_valid0, step0, gray_err0, err_cnt0);
      end
      for (int k = 1; k <= 5; k++) begin
         tick();
         n_tests++;
         if (sync_valid0 !== (k >= 3) || step0 !== 1'b0 || gray_err0 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_refill edge %0d: valid=%b step=%b err=%b required %b 0 0",
                     k, sync_valid0, step0, gray_err0, (k >= 3));
         end
      end
      n_tests++;
      if (sync_bin0 !== 4'd9) begin
         n_fail++;
         $display("FAIL mid_refill_bin: got %0d required 9", sync_bin0);
      end
   endtask

   task automatic test_depth();
      async1 = 5'b00000;
      rst1   = 1'b1;
      tick();
      rst1 = 1'b0;
      repeat (8) tick();
      n_tests++;
      if (sync_valid1 !== 1'b1 || sync_bin1 !== 5'd0) begin
         n_fail++;
         $display("FAIL depth_settle: valid=%b bin=%0d required 1 0", sync_valid1, sync_bin1);
      end
      async1 = 5'b00001;
      for (int k = 1; k <= 5; k++) begin
         tick();
         n_tests++;
         if (sync_sig1 !== ((k >= 4) ? 5'b00001 : 5'b00000)) begin
            n_fail++;
            $display("FAIL depth_sig edge %0d: got %b", k, sync_sig1);
         end
         n_tests++;
         if (sync_bin1 !== ((k >= 5) ? 5'd1 : 5'd0) || step1 !== (k == 5)) begin
            n_fail++;
            $display("FAIL depth_bin edge %0d: bin=%0d step=%b", k, sync_bin1, step1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_wrap();
      test_illegal();
      test_saturate();
      test_reset_mid();
      test_depth();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_ptr_sync.md
# gray_ptr_sync

Parametrised multi-stage gray-code pointer synchronizer with built-in decode and integrity checking for the async FIFO. It brings a gray-coded pointer from the opposite clock domain into `dest_clk` through a configurable-depth flop chain. It then converts the result to binary, flags each pointer step and detects illegal multi-bit gray transitions. It replaces the fixed two-flop pointer synchronizer on both the read-side and write-side pointer crossings.

## Interface
- `ASIZE`, 3, pointer MSB index; all pointer buses are `ASIZE+1` bits (FIFO address width plus wrap bit).
- `STAGES`, 2, number of synchronizer flops; legal range 2..8; any other value must cause an elaboration error.
- `dest_clk`  in  1  destination-domain clock; all flops are rising-edge.
- `in_reset`  in  1  reset. One clock; reset is synchronous and active-high.
- `async_signal`  in  ASIZE+1  gray-coded pointer from the source domain (asynchronous to `dest_clk`).
- `sync_signal`  out  ASIZE+1  gray pointer after `STAGES` flops.
- `sync_bin`  out  ASIZE+1  registered binary decode of `sync_signal`.
- `sync_valid`  out  1  high once the chain and decode register hold post-reset data.
- `step`  out  1  one-cycle pulse when the synchronized pointer changed.
- `gray_err`  out  1  sticky: an illegal (>1 bit) gray transition has been seen.
- `err_cnt`  out  8  saturating count of illegal transitions.

## Operation
- Chain: `s[1] <= async_signal`, `s[k] <= s[k-1]` for k = 2..STAGES. `sync_signal = s[STAGES]` (direct flop output, no logic).
- Decode register, updated every non-reset edge:
  - `sync_bin <= g2b(sync_signal)`, where `b[ASIZE] = g[ASIZE]` and `b[i] = b[i+1] ^ g[i]`.
  - `cmp_q <= sync_signal`.
- Fill counter `cnt`, width ceil(log2(STAGES+2)), increments by 1 per edge and saturates at `STAGES+1`. `sync_valid` is registered and is high iff `cnt == STAGES+1`.
- Checks are evaluated only on edges where `sync_valid` is already 1. `d = sync_signal ^ cmp_q`.
  - `step <= (d != 0)`.
  - Illegal event when popcount(d) > 1: `gray_err <= 1` (sticky) and `err_cnt <= err_cnt + 1`, saturating at 255.
  - On edges where `sync_valid` is 0, `step <= 0` and the error state holds.
- Wrap-around: max → 0 (gray `1000...0` → `0000...0`) is a single-bit change. It is legal and produces `step`.
- An illegal transition still updates `sync_bin` to the decode of the new value. It is never filtered.
- Reset (`in_reset` high at an edge), including mid-operation:
  - All chain stages, `cmp_q`, `sync_bin`, `cnt`, `sync_valid`, `step`, `gray_err` and `err_cnt` go to 0.
  - The fill sequence restarts after release.

## Timing
- Reset values: `sync_signal` = 0, `sync_bin` = 0, `sync_valid` = 0, `step` = 0, `gray_err` = 0, `err_cnt` = 0.
- Latency: an `async_signal` change captured at edge N appears on `sync_signal` after edge N+STAGES-1. It appears on `sync_bin`, `step` and `gray_err` after edge N+STAGES.
- After reset release, counting the first non-reset edge as edge 1: `sync_valid` rises after edge STAGES+1. The first comparison happens at edge STAGES+2.
- Input stability assumption: `async_signal` changes by at most one gray step per `dest_clk` period. A faster source is caught by `gray_err` and never causes silent mis-decode.
- `step` is high for exactly one cycle per change. Consecutive changes on consecutive edges give `step` high on consecutive cycles.

## Test plan
- Latency/fill, ASIZE=3, STAGES=2: hold `async_signal`=4'b0110 through reset and release.
  - Required: `sync_signal`=0110 after edge 2.
  - Required: `sync_bin`=4 and `sync_valid`=1 after edge 3.
  - Required: `step`=0 and `gray_err`=0 throughout.
- Count with wrap: drive gray(0..15) then gray(0), one value every 3 cycles.
  - Required: `sync_bin` follows 0..15,0.
  - Required: exactly 16 single-cycle `step` pulses, including 15→0.
  - Required: `gray_err`=0.
- Illegal jump: from settled 4'b0000, drive 4'b0011.
  - Required: `gray_err`=1 and `err_cnt`=1, 3 cycles after the input edge; `sync_bin`=2.
  - Required: `gray_err` stays 1 after a subsequent legal change.
- Saturation: apply 300 alternating 0000↔0011 transitions, 3 cycles apart.
  - Required: `err_cnt`=255 and holds; no wrap.
- Reset mid-operation: with `sync_bin`=9, `gray_err`=1, `err_cnt`=5, assert `in_reset` for 1 edge.
  - Required: every output is 0 after that edge.
  - Required: `sync_valid` returns STAGES+1 edges after release, with no spurious `step`.
- Depth: ASIZE=4, STAGES=4. Drive a step 00000→00001.
  - Required: `sync_signal` changes exactly 4 edges after capture and `sync_bin`=1 one edge later.
  - Required: STAGES=1 fails elaboration.
